// File: rtl/voltmeter_pkg.sv
// Shared types and constants for the dual-slope voltmeter front end:
// sequencer state encoding, pulse counter geometry and the switch map.
package voltmeter_pkg;

   localparam int PULSE_WRAP  = 1000;
   localparam int PULSE_CNT_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_AUTOZERO    = 3'd1,
      ST_INTEGRATE   = 3'd2,
      ST_DEINTEGRATE = 3'd3,
      ST_DONE        = 3'd4
   } state_t;

   typedef struct packed {
      logic az;
      logic in_sel;
      logic ref_sel;
   } sw_t;

   // Exactly one analog switch closed per state; autozero is the safe default.
   function automatic sw_t switch_map(input state_t s);
      sw_t sw;
      sw = '0;
      case (s)
         ST_INTEGRATE:   sw.in_sel  = 1'b1;
         ST_DEINTEGRATE: sw.ref_sel = 1'b1;
         default:        sw.az      = 1'b1;
      endcase
      return sw;
   endfunction

endpackage

// File: rtl/dual_slope_sequencer_comp_sync.sv
// Two-flop synchronizer bringing the asynchronous zero-cross comparator
// into the clk_i domain; both stages clear on reset.
module comp_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so both stages
   // sample the pre-edge values and the chain really delays by two clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/dual_slope_sequencer.sv
// Dual-slope conversion controller: autozero, fixed integrate, deintegrate
// until comparator trip or timeout. Optional macro CONT_MODE_EN chains
// conversions back to back without further start_i requests.
module dual_slope_sequencer
   import voltmeter_pkg::*;
#(
   parameter int AZ_PERIODS      = 2,
   parameter int INTEG_PERIODS   = 1,
   parameter int TIMEOUT_PERIODS = 3,
   parameter int RES_W           = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   comp_i,
   input  logic                   increment_i,
   input  logic [PULSE_CNT_W-1:0] pulse_count_i,
   output logic                   trigger_o,
   output logic                   stop_o,
   output logic                   sw_az_o,
   output logic                   sw_in_o,
   output logic                   sw_ref_o,
   output logic                   busy_o,
   output logic [RES_W-1:0]       result_o,
   output logic                   result_valid_o,
   output logic                   overrange_o
);

   localparam int WRAP_W = 8;

   state_t            state, state_nxt;
   logic [WRAP_W-1:0] wraps, wraps_nxt;
   logic              inc_prev, inc_rise;
   logic              comp_s;
   logic              trig, capture, timeout;
   sw_t               sw_nxt;

   comp_sync u_comp_sync (
      .clk  (clk_i),
      .rst  (rst_i),
      .din  (comp_i),
      .dout (comp_s)
   );

   // A stopped counter can sit at 1000 with increment_i held high, so only
   // rising edges count as wraps.
   assign inc_rise = increment_i & ~inc_prev;
   assign sw_nxt   = switch_map(state_nxt);

   // NOTE: every always_comb output gets a default first so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      wraps_nxt = wraps;
      trig      = 1'b0;
      capture   = 1'b0;
      timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               state_nxt = ST_AUTOZERO;
               trig      = 1'b1;
               wraps_nxt = '0;
            end
         end
         ST_AUTOZERO: begin
            if (inc_rise) begin
               if (wraps == WRAP_W'(AZ_PERIODS - 1)) begin
                  state_nxt = ST_INTEGRATE;
                  wraps_nxt = '0;
               end else begin
                  wraps_nxt = wraps + 1'b1;
               end
            end
         end
         ST_INTEGRATE: begin
            if (inc_rise) begin
               if (wraps == WRAP_W'(INTEG_PERIODS - 1)) begin
                  state_nxt = ST_DEINTEGRATE;
                  wraps_nxt = '0;
               end else begin
                  wraps_nxt = wraps + 1'b1;
               end
            end
         end
         ST_DEINTEGRATE: begin
            // A trip coinciding with a wrap wins and uses the pre-wrap thousands.
            if (comp_s) begin
               capture   = 1'b1;
               state_nxt = ST_DONE;
            end else if (inc_rise) begin
               if (wraps == WRAP_W'(TIMEOUT_PERIODS - 1)) begin
                  timeout   = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  wraps_nxt = wraps + 1'b1;
               end
            end
         end
         ST_DONE: begin
`ifdef CONT_MODE_EN
            state_nxt = ST_AUTOZERO;
            trig      = 1'b1;
            wraps_nxt = '0;
`else
            state_nxt = ST_IDLE;
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= ST_IDLE;
         wraps          <= '0;
         inc_prev       <= 1'b0;
         trigger_o      <= 1'b0;
         stop_o         <= 1'b0;
         sw_az_o        <= 1'b1;
         sw_in_o        <= 1'b0;
         sw_ref_o       <= 1'b0;
         busy_o         <= 1'b0;
         result_o       <= '0;
         result_valid_o <= 1'b0;
         overrange_o    <= 1'b0;
      end else begin
         state          <= state_nxt;
         wraps          <= wraps_nxt;
         inc_prev       <= (state inside {ST_AUTOZERO, ST_INTEGRATE, ST_DEINTEGRATE})
                           ? increment_i : 1'b0;
         trigger_o      <= trig;
         stop_o         <= capture | timeout;
         sw_az_o        <= sw_nxt.az;
         sw_in_o        <= sw_nxt.in_sel;
         sw_ref_o       <= sw_nxt.ref_sel;
         busy_o         <= (state_nxt != ST_IDLE);
         result_valid_o <= (state == ST_DONE);
         if (capture) begin
            result_o    <= RES_W'(wraps) * RES_W'(PULSE_WRAP) + RES_W'(pulse_count_i);
            overrange_o <= 1'b0;
         end else if (timeout) begin
            result_o    <= RES_W'(TIMEOUT_PERIODS * PULSE_WRAP);
            overrange_o <= 1'b1;
         end
      end
   end

endmodule
